// File: rtl/page_table_memory.sv
// Read-only page-table backing store: single outstanding word read over
// valid/ready request and response channels, preloaded two-level table image.
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE        | ready for a request; address latched on accepting edge
// READ_ACCESS | access delay counting down; data captured on terminal count
// RESPOND     | response valid, data held until the requester accepts it
module page_table_memory #(
  parameter int DEPTH_WORDS    = 1024,
  parameter int ACCESS_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_valid_i,
  output logic        mem_req_ready_o,
  input  logic [31:0] mem_addr_i,
  output logic        mem_resp_valid_o,
  input  logic        mem_resp_ready_i,
  output logic [31:0] mem_data_o
);

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    READ_ACCESS = 2'b01,
    RESPOND     = 2'b10
  } state_t;

  localparam int          CNT_W      = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_LATENCY - 1);
  localparam logic [30:0] DEPTH_L    = 31'(DEPTH_WORDS);

  state_t            state_q;
  state_t            state_d;
  logic [29:0]       word_q;
  logic [CNT_W-1:0]  lat_cnt_q;
  logic [31:0]       data_q;

  logic              req_fire;
  logic              resp_fire;
  logic              lat_tc;
  logic              in_range;
  logic [31:0]       rom_data;
  logic              unused_addr_lsbs;

  // Byte-offset bits never select anything in a word-addressed array.
  assign unused_addr_lsbs = ^mem_addr_i[1:0];

  assign req_fire  = (state_q == IDLE) && mem_req_valid_i;
  assign resp_fire = (state_q == RESPOND) && mem_resp_ready_i;
  assign lat_tc    = (lat_cnt_q == '0);
  assign in_range  = ({1'b0, word_q} < DEPTH_L);

  // Fixed page-table image, indexed by word; everything else reads as zero.
  function automatic logic [31:0] rom_word(input logic [29:0] idx);
    logic [31:0] w;
    case (idx)
      30'h100: w = 32'h0000_0801;
      30'h101: w = 32'h1234_0007;
      30'h200: w = 32'h1000_000F;
      30'h201: w = 32'h1100_000F;
      30'h202: w = 32'h1200_0007;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  assign rom_data = in_range ? rom_word(word_q) : 32'h0000_0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_req_valid_i) begin
          state_d = READ_ACCESS;
        end
      end
      READ_ACCESS: begin
        if (lat_tc) begin
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        if (mem_resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_ready_o  = 1'b0;
    mem_resp_valid_o = 1'b0;
    case (state_q)
      IDLE:    mem_req_ready_o  = 1'b1;
      RESPOND: mem_resp_valid_o = 1'b1;
      default: begin
        mem_req_ready_o  = 1'b0;
        mem_resp_valid_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q    <= '0;
      lat_cnt_q <= '0;
      data_q    <= '0;
    end else begin
      if (req_fire) begin
        word_q    <= mem_addr_i[31:2];
        lat_cnt_q <= CNT_LOAD;
      end else if (state_q == READ_ACCESS) begin
        if (lat_tc) begin
          data_q <= rom_data;
        end else begin
          lat_cnt_q <= lat_cnt_q - 1'b1;
        end
      end
    end
  end

  assign mem_data_o = data_q;

  logic unused_resp_fire;
  assign unused_resp_fire = resp_fire;

endmodule

// File: tb/tb_page_table_memory.sv
// Directed bench for page_table_memory: transaction-level reference model
// checked every cycle, plus literal expectations per read.
module tb_page_table_memory;

  localparam int DEPTH = 1024;
  localparam int LAT   = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] data;

  int total = 0;
  int bad   = 0;

  page_table_memory #(.DEPTH_WORDS(DEPTH), .ACCESS_LATENCY(LAT)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_req_valid_i  (req_valid),
    .mem_req_ready_o  (req_ready),
    .mem_addr_i       (addr),
    .mem_resp_valid_o (resp_valid),
    .mem_resp_ready_i (resp_ready),
    .mem_data_o       (data)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    logic [31:0] w;
    w = 32'h0;
    if ((a >> 2) < DEPTH) begin
      case (a & 32'hFFFF_FFFC)
        32'h400: w = 32'h0000_0801;
        32'h404: w = 32'h1234_0007;
        32'h800: w = 32'h1000_000F;
        32'h804: w = 32'h1100_000F;
        32'h808: w = 32'h1200_0007;
        default: w = 32'h0;
      endcase
    end
    return w;
  endfunction

  // Transaction-level model: busy for LAT edges after acceptance, then a
  // pending response until the requester takes it.
  bit          m_busy = 0;
  bit          m_resp = 0;
  int          m_wait = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  bit          cmp_en = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_resp = 0; m_wait = 0; m_addr = '0; m_data = '0;
    end else if (m_resp) begin
      if (resp_ready) m_resp = 0;
    end else if (m_busy) begin
      m_wait--;
      if (m_wait == 0) begin
        m_busy = 0;
        m_resp = 1;
        m_data = mem_model(m_addr);
      end
    end else if (req_valid) begin
      m_busy = 1;
      m_wait = LAT;
      m_addr = addr;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_ready", {31'b0, req_ready}, {31'b0, !m_busy && !m_resp});
      check("model_valid", {31'b0, resp_valid}, {31'b0, m_resp});
      check("model_data", data, m_data);
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge after the
  // response handshake so a following call issues back-to-back.
  task automatic read_txn(input logic [31:0] a, input logic [31:0] exp,
                          input int hold, input int rdy_cycles);
    int n;
    check("idle_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    addr      = a;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    addr      = a ^ 32'hDEAD_BEE0;
    check("ready_drop", {31'b0, req_ready}, 32'd0);
    n = 1;
    while (!resp_valid && n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency_edges", n, 32'(LAT + 1));
    check("rd_data", data, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_data", data, exp);
    end
    resp_ready = 1'b1;
    for (int i = 0; i < rdy_cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    resp_ready = 1'b0;
    check("done_valid", {31'b0, resp_valid}, 32'd0);
    check("done_ready", {31'b0, req_ready}, 32'd1);
    check("data_held", data, exp);
  endtask

  logic [31:0] addrs [13] = '{32'h000, 32'h004, 32'h100, 32'h400, 32'h404, 32'h408,
                              32'h800, 32'h804, 32'h808, 32'h80C, 32'hFFC, 32'h1000,
                              32'h10000};
  logic [31:0] exps  [13] = '{32'h0, 32'h0, 32'h0, 32'h0000_0801, 32'h1234_0007, 32'h0,
                              32'h1000_000F, 32'h1100_000F, 32'h1200_0007, 32'h0, 32'h0,
                              32'h0, 32'h0};

  initial begin
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_data", data, 32'd0);
    rst    = 1'b1;
    cmp_en = 1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      check("model_pin", mem_model(addrs[i]), exps[i]);
      read_txn(addrs[i], exps[i], 0, 1);
    end

    read_txn(32'h404, 32'h1234_0007, 10, 2);
    read_txn(32'h407, 32'h1234_0007, 0, 1);

    for (int i = 0; i < 10; i++) begin
      read_txn(addrs[(i * 3 + 4) % 13], exps[(i * 3 + 4) % 13], 0, 1);
    end

    req_valid = 1'b1;
    addr      = 32'h404;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_busy", {31'b0, req_ready}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
    check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    check("mid_rst_data", data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    read_txn(32'h800, 32'h1000_000F, 0, 1);
    repeat (3) @(negedge clk);

    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/page_table_memory.md
# page_table_memory

Read-only, word-addressed backing memory that serves single-beat read requests over a valid/ready request channel and a valid/ready response channel. It models the physical memory holding page tables for the TLB/page-table-walker subsystem. It comes preloaded with a small two-level page-table image. Accesses outside the array return zero.

## Interface
Parameters:
- DEPTH_WORDS, 1024 — number of 32-bit words; byte range 0x0000–0x0FFF.
- ACCESS_LATENCY, 1 — cycles spent in READ_ACCESS; minimum 1.

Ports:
- clk  in  1  — single clock; all state updates on its rising edge.
- rst  in  1  — asynchronous, active-low reset.
- mem_req_valid_i  in  1  — read request valid.
- mem_req_ready_o  out  1  — memory can accept a request.
- mem_addr_i  in  32  — byte address of the read.
- mem_resp_valid_o  out  1  — response data valid.
- mem_resp_ready_i  in  1  — requester accepts the response.
- mem_data_o  out  32  — read data.

## Operation
- Storage: DEPTH_WORDS × 32-bit array. Word index = addr[31:2]; addr[1:0] are ignored.
- Contents are fixed at elaboration and are not altered by reset. There is no write port.
- Initial image (byte address = value):
  - 0x400 = 0x00000801
  - 0x404 = 0x12340007
  - 0x800 = 0x1000000F
  - 0x804 = 0x1100000F
  - 0x808 = 0x12000007
  - All other words = 0.
- Out of range: if word index ≥ DEPTH_WORDS (e.g. 0x1000, 0x10000), read data = 0x00000000. No error is flagged.
- FSM states are IDLE, READ_ACCESS, RESPOND.
  - IDLE: mem_req_ready_o = 1. On a clock edge with mem_req_valid_i = 1, latch mem_addr_i and go to READ_ACCESS.
  - READ_ACCESS: mem_req_ready_o = 0. Count ACCESS_LATENCY cycles. On the last cycle, register the read data (or 0 if out of range) into mem_data_o and go to RESPOND.
  - RESPOND: mem_resp_valid_o = 1 and mem_data_o is held stable. On a clock edge with mem_resp_ready_i = 1, go to IDLE. Otherwise stay in RESPOND indefinitely.
- Only one request is outstanding at a time. mem_req_valid_i is ignored outside IDLE.
- mem_addr_i changes after acceptance have no effect, because the address is latched.
- In IDLE, mem_resp_ready_i is ignored.
- State encoding: IDLE = 2'b00, READ_ACCESS = 2'b01, RESPOND = 2'b10. An unused encoding returns to IDLE.

## Timing
- Reset values (while rst = 0):
  - state = IDLE
  - mem_req_ready_o = 1
  - mem_resp_valid_o = 0
  - mem_data_o = 0
  - latched address = 0
- Reset asserted mid-transaction aborts immediately. Any pending response is dropped and the block returns to IDLE.
- mem_req_ready_o and mem_resp_valid_o are decoded from registered state, so there is no combinational path from the inputs.
- Request handshake: a transfer occurs on the rising edge where mem_req_valid_i = 1 and mem_req_ready_o = 1. mem_req_ready_o falls in the cycle immediately after that edge.
- Latency: mem_resp_valid_o rises ACCESS_LATENCY + 1 edges after the accepting edge. With the default, that is 2 edges after acceptance.
- Response handshake: completes on the edge where mem_resp_valid_o = 1 and mem_resp_ready_i = 1. Then mem_resp_valid_o = 0 and mem_req_ready_o = 1 on the following cycle.
- mem_data_o keeps its last value after the response completes, until the next read loads it.
- Back-to-back operation: a new request may be accepted on the first IDLE edge after the response handshake.
- Holding mem_resp_ready_i high longer than one cycle is harmless. The second cycle occurs in IDLE and is ignored.

## Test plan
- Reset: hold rst = 0 for 2 cycles, then release → mem_req_ready_o = 1, mem_resp_valid_o = 0, mem_data_o = 0.
- Uninitialized reads of 0x000, 0x004, 0x100 → data 0x00000000 each. mem_req_ready_o drops the cycle after acceptance. mem_resp_valid_o rises 2 edges after acceptance.
- Page-table reads:
  - 0x400 → 0x00000801
  - 0x404 → 0x12340007
  - 0x408 → 0
  - 0x800 → 0x1000000F
  - 0x804 → 0x1100000F
  - 0x808 → 0x12000007
  - 0x80C → 0
- Boundaries: 0xFFC → 0; 0x1000 → 0; 0x10000 → 0. Each completes a normal handshake with no hang.
- Backpressure: issue a read of 0x404 and keep mem_resp_ready_i = 0 for 10 cycles → mem_resp_valid_o stays 1 and data stays 0x12340007. Then assert mem_resp_ready_i for 2 cycles → returns to IDLE with mem_req_ready_o = 1.
- Stress and mid-operation reset:
  - Run 10 consecutive reads across the addresses above → all match.
  - Assert rst during READ_ACCESS → mem_resp_valid_o = 0 and mem_req_ready_o = 1 immediately.
  - The next read of 0x800 afterwards → 0x1000000F.
